// File: rtl/game_state_ctrl_pkg.sv
// Shared definitions for the game state controller and its neighbours
// (pixel mux, text renderer).
//   state_e          : TITLE/PLAY/OVER encodings driven on state_o
//   START_LIVES_DEF  : default lives loaded at each game start
//   BTN_*            : bit positions inside the press vector
//   COL_*            : 12-bit RGB colour constants
//   popcount3        : number of set bits in a 3-bit pulse vector
package game_state_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_TITLE = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b10
  } state_e;

  localparam int unsigned START_LIVES_DEF = 3;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;

  localparam logic [11:0] COL_BG       = 12'h000;
  localparam logic [11:0] COL_SHIP     = 12'hFFF;
  localparam logic [11:0] COL_ASTEROID = 12'h888;
  localparam logic [11:0] COL_TEXT     = 12'h0F0;
  localparam logic [11:0] COL_OVER     = 12'hF00;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/game_state_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and
// rising-edge detector.
//   clk, rst : system clock, asynchronous active-high reset
//   btn_i    : raw asynchronous button level
//   press_o  : one-clk pulse, one clk after the accepted level rises
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          prev_q;
  logic          arm_q;
  logic          press_q;

  // Counter runs only while the synchronized level differs from the
  // accepted one; any agreeing sample (a bounce) clears it.
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        lvl_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer resets high and arm_q stays low until a released level is
  // seen, so a button held through reset gives no press until re-pressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      prev_q  <= 1'b0;
      arm_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      prev_q  <= lvl_q;
      arm_q   <= arm_q | ~sync2_q;
      press_q <= arm_q & lvl_q & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game state controller: TITLE / PLAY / OVER sequencing, lives with
// post-hit invulnerability, saturating score, debounced button presses.
//   clk, rst          : 100 MHz clock, asynchronous active-high reset
//   frame_tick_i      : one-clk pulse per frame
//   btn_*_i           : raw push-buttons
//   hit_i[2:0]        : per-asteroid ship-collision pulses
//   score_inc_i[2:0]  : per-asteroid destroyed pulses
//   state_o[1:0]      : 00 TITLE, 01 PLAY, 10 OVER
//   lives_o[1:0]      : remaining lives
//   score_o[7:0]      : binary score
//   press_o[3:0]      : debounced press pulses {right,left,down,up}
//   game_over_o       : one-clk pulse on every PLAY->OVER transition
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int unsigned START_LIVES     = START_LIVES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HIT_GRACE       = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic [2:0] hit_i,
  input  logic [2:0] score_inc_i,
  output logic [1:0] state_o,
  output logic [1:0] lives_o,
  output logic [7:0] score_o,
  output logic [3:0] press_o,
  output logic       game_over_o
);

  localparam int unsigned GW = (HIT_GRACE > 0) ? $clog2(HIT_GRACE + 1) : 1;

  logic [3:0] btn_raw;
  logic [3:0] press;

  assign btn_raw = {btn_right_i, btn_left_i, btn_down_i, btn_up_i};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn_raw[i]),
      .press_o(press[i])
    );
  end

  state_e        state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic [7:0]    score_q, score_d;
  logic [GW-1:0] grace_q, grace_d;
  logic          game_over_q, game_over_d;
  logic [8:0]    score_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_TITLE;
      lives_q     <= '0;
      score_q     <= '0;
      grace_q     <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      grace_q     <= grace_d;
      game_over_q <= game_over_d;
    end
  end

  // Leaving PLAY keys off the registered lives value, so the state moves
  // to OVER the clk after the last life is lost.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TITLE: if (|press) state_d = ST_PLAY;
      ST_PLAY:  if ((lives_q == '0) || press[BTN_DOWN]) state_d = ST_OVER;
      ST_OVER: begin
        if (press[BTN_UP])         state_d = ST_TITLE;
        else if (press[BTN_RIGHT]) state_d = ST_PLAY;
      end
      default:  state_d = ST_TITLE;
    endcase
  end

  always_comb begin
    lives_d     = lives_q;
    score_d     = score_q;
    grace_d     = grace_q;
    game_over_d = 1'b0;
    score_sum   = {1'b0, score_q} + {7'b0, popcount3(score_inc_i)};
    case (state_q)
      ST_TITLE: begin
        if (state_d == ST_PLAY) begin
          lives_d = 2'(START_LIVES);
          score_d = '0;
          grace_d = '0;
        end
      end
      ST_PLAY: begin
        score_d = score_sum[8] ? '1 : score_sum[7:0];
        // A hit load takes priority over the frame countdown; lives_q check
        // keeps the transitional zero-lives clk from wrapping.
        if ((|hit_i) && (grace_q == '0) && (lives_q != '0)) begin
          lives_d = lives_q - 2'd1;
          grace_d = GW'(HIT_GRACE);
        end else if (frame_tick_i && (grace_q != '0)) begin
          grace_d = grace_q - GW'(1);
        end
        game_over_d = (state_d == ST_OVER);
      end
      ST_OVER: begin
        if (state_d == ST_TITLE) begin
          lives_d = '0;
        end else if (state_d == ST_PLAY) begin
          lives_d = 2'(START_LIVES);
          score_d = '0;
          grace_d = '0;
        end
      end
      default: begin
        lives_d = '0;
        score_d = '0;
        grace_d = '0;
      end
    endcase
  end

  assign state_o     = state_q;
  assign lives_o     = lives_q;
  assign score_o     = score_q;
  assign press_o     = press;
  assign game_over_o = game_over_q;

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameter START_LIVES, default 3; lives loaded on each game start (1..3).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000; stable clk cycles required before a button level is accepted.
REQ-003 Parameter HIT_GRACE, default 60; frames of invulnerability after a life is lost.
REQ-004 clk  in  1  100 MHz system clock.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 frame_tick  in  1  one-clk pulse per frame (start of vblank).
REQ-007 btn_up, btn_down, btn_left, btn_right  in  1 each  raw asynchronous push-buttons.
REQ-008 hit  in  3  per-asteroid ship-collision pulses, one clk wide.
REQ-009 score_inc  in  3  per-asteroid destroyed pulses, one clk wide.
REQ-010 state  out  2  00 TITLE, 01 PLAY, 10 OVER; registered.
REQ-011 lives  out  2  remaining lives; registered.
REQ-012 score  out  8  binary score for the score renderer; registered.
REQ-013 press  out  4  debounced rising-edge pulses {right,left,down,up}, one clk wide.
REQ-014 game_over  out  1  one-clk pulse on every PLAY->OVER transition.

Function
REQ-015 Each button: 2-FF synchronizer, then counter; accepted level changes only after DEBOUNCE_CYCLES consecutive clk cycles of a differing synchronized level; counter clears on any bounce.
REQ-016 press[i] asserts exactly one clk after accepted level goes 0->1; no pulse on release.
REQ-017 TITLE: any press bit -> PLAY next clk; same edge loads lives=START_LIVES, score=0, grace=0.
REQ-018 PLAY, life loss: in a clk with |hit=1 and grace==0, lives decrements by 1 (multiple hit bits same cycle = one life) and grace loads HIT_GRACE.
REQ-019 PLAY, grace: decrements by 1 on each frame_tick while nonzero; hits ignored while nonzero.
REQ-020 PLAY: transition to OVER the clk after lives becomes 0, or on press[down]; game_over pulses on that transition edge.
REQ-021 PLAY, scoring: score += popcount(score_inc) each clk; saturates at 255, never wraps.
REQ-022 Simultaneous hit and score_inc in one clk: both applied.
REQ-023 Final hit and press[down] in same clk: single OVER transition, single game_over pulse.
REQ-024 OVER: score and lives frozen; hit/score_inc ignored.
REQ-025 OVER: press[up] -> TITLE; press[right] -> PLAY with re-init per REQ-017; both same clk -> TITLE wins.
REQ-026 Encoding 11 -> TITLE on next clk, with lives=0 and score=0.
REQ-027 TITLE: score holds last game value, lives=0, hit/score_inc ignored.
REQ-028 State-transition latency: one clk from the press pulse; total button-to-state latency is 2 + DEBOUNCE_CYCLES + 2 clk.

Reset
REQ-029 During rst: state=TITLE, lives=0, score=0, grace=0, press=0, game_over=0, debounce counters=0, accepted levels=0.
REQ-030 Reset mid-game aborts immediately; no game_over pulse is generated by reset.
REQ-031 A button held through reset release produces no press until released and pressed again.

Structure
REQ-032 Shared package holds state encodings (TITLE/PLAY/OVER), colour constants, and START_LIVES default; the top-level pixel mux and the text renderer import the same encodings.
REQ-033 One sub-module, btn_debounce (synchronizer + counter + edge detect, parameter DEBOUNCE_CYCLES), instantiated four times.
REQ-034 Bench overrides DEBOUNCE_CYCLES=4 and HIT_GRACE=2.

Verification
REQ-035 Raw btn_left toggles every 2 clk for 20 clk, then stays high -> exactly one press[left] pulse, 6-7 clk after it stabilizes; state 00->01 one clk later.
REQ-036 PLAY, lives=3: hit=3'b111 one clk -> lives=2 and grace=2; hit after 1 frame_tick -> lives unchanged; hit after 2nd tick -> lives=1.
REQ-037 PLAY, score=254: score_inc=3'b011 -> score=255; a further score_inc=3'b111 -> score stays 255.
REQ-038 lives=1, grace=0: hit plus press[down] same clk -> lives=0, state=10, exactly one game_over pulse.
REQ-039 OVER: press[up] and press[right] same clk -> state=00; then press[right] alone from TITLE -> state=01, lives=3, score=0.
REQ-040 PLAY, score=40: rst asserted for one clk -> state=00, lives=0, score=0, game_over never pulses.
